// File: rtl/c17_pkg.sv
// c17_pkg -- shared constants and counter-width helpers for the c17 block.
//   CNT_W_DEF : default toggle-counter width
//   CNT_W_MIN / CNT_W_MAX : legal counter width range
//   sat_max() : saturation ceiling (all ones) for a given counter width
package c17_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned CNT_W_MIN = 4;
  localparam int unsigned CNT_W_MAX = 32;

  // All-ones value of a w-bit counter, right-aligned in a CNT_W_MAX word.
  // Callers truncate to their own width; widths above CNT_W_MAX clamp.
  function automatic logic [CNT_W_MAX-1:0] sat_max(input int unsigned w);
    if (w >= CNT_W_MAX) return {CNT_W_MAX{1'b1}};
    return {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - w);
  endfunction

endpackage

// File: rtl/c17_toggle_ctr.sv
// c17_toggle_ctr -- registers one c17 output and counts its toggles.
//   clk, rst   : clock, synchronous active-high reset (priority over cnt_clr)
//   d          : combinational c17 output to track
//   cnt_clr    : synchronous clear of the counter (q still loads d)
//   q          : d registered on clk
//   cnt        : saturating count of edges where d != q
module c17_toggle_ctr
  import c17_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             cnt_clr,
  output logic             q,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  // A toggle is d about to differ from what q currently holds, so the
  // first 1 after reset counts (q resets to 0).
  logic toggle;
  assign toggle = d ^ q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else begin
      q <= d;
      if (cnt_clr)
        cnt <= '0;
      else if (toggle && (cnt != CNT_MAX))
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/c17.sv
// c17 -- ISCAS85 c17 NAND netlist with registered outputs and toggle counters.
//   clk, rst            : clock, synchronous active-high reset
//   N1,N2,N3,N6,N7      : netlist primary inputs
//   cnt_clr             : synchronous clear of both toggle counters
//   N22, N23            : combinational netlist outputs (no clock/reset path)
//   N22_q, N23_q        : N22/N23 registered on clk
//   cnt_n22, cnt_n23    : saturating toggle counts of N22_q / N23_q
module c17
  import c17_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             N1,
  input  logic             N2,
  input  logic             N3,
  input  logic             N6,
  input  logic             N7,
  input  logic             cnt_clr,
  output logic             N22,
  output logic             N23,
  output logic             N22_q,
  output logic             N23_q,
  output logic [CNT_W-1:0] cnt_n22,
  output logic [CNT_W-1:0] cnt_n23
);

  logic N10, N11, N16, N19;

  // Gate-for-gate c17; kept as named nets so the netlist stays traceable.
  assign N10 = ~(N1  & N3);
  assign N11 = ~(N3  & N6);
  assign N16 = ~(N2  & N11);
  assign N19 = ~(N11 & N7);
  assign N22 = ~(N10 & N16);
  assign N23 = ~(N16 & N19);

  c17_toggle_ctr #(.CNT_W(CNT_W)) u_ctr_n22 (
    .clk     (clk),
    .rst     (rst),
    .d       (N22),
    .cnt_clr (cnt_clr),
    .q       (N22_q),
    .cnt     (cnt_n22)
  );

  c17_toggle_ctr #(.CNT_W(CNT_W)) u_ctr_n23 (
    .clk     (clk),
    .rst     (rst),
    .d       (N23),
    .cnt_clr (cnt_clr),
    .q       (N23_q),
    .cnt     (cnt_n23)
  );

endmodule

// File: tb/tb_c17.sv
// tb_c17 -- directed + exhaustive bench for c17 (CNT_W=16 and CNT_W=4 copies
// driven in parallel). Inputs change 1 ns after posedge; combinational
// outputs are checked at negedge, registered outputs 1 ns after the next edge.
module tb_c17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n1 = 0, n2 = 0, n3 = 0, n6 = 0, n7 = 0;
  logic cnt_clr = 1'b0;

  logic        w22, w23, w22q, w23q;
  logic [15:0] wc22, wc23;
  logic        s22, s23, s22q, s23q;
  logic [3:0]  sc22, sc23;

  always #5 clk = ~clk;

  c17 #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .cnt_clr(cnt_clr), .N22(w22), .N23(w23), .N22_q(w22q), .N23_q(w23q),
    .cnt_n22(wc22), .cnt_n23(wc23)
  );

  c17 #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .cnt_clr(cnt_clr), .N22(s22), .N23(s23), .N22_q(s22q), .N23_q(s23q),
    .cnt_n22(sc22), .cnt_n23(sc23)
  );

  typedef struct {
    logic        q22, q23;
    logic [15:0] c22, c23;
    logic [3:0]  s22, s23;
  } reg_exp_t;

  logic [1:0] comb_q[$];
  reg_exp_t   reg_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic        m_q22 = 0, m_q23 = 0;
  logic [15:0] m_c22 = 0, m_c23 = 0;
  logic [3:0]  m_s22 = 0, m_s23 = 0;

  // Golden c17: vector order {N1,N2,N3,N6,N7}; returns {N22,N23}.
  function automatic logic [1:0] gold(input logic [4:0] v);
    logic a1, a2, a3, a6, a7, g10, g11, g16, g19;
    {a1, a2, a3, a6, a7} = v;
    g10 = ~(a1 & a3);
    g11 = ~(a3 & a6);
    g16 = ~(a2 & g11);
    g19 = ~(g11 & a7);
    return {~(g10 & g16), ~(g16 & g19)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check results of the edge just taken, drive new inputs,
  // check combinational outputs at negedge, then predict the next edge.
  task automatic step(input logic [4:0] v, input logic c, input logic r);
    logic [1:0] g;
    reg_exp_t   e;
    @(posedge clk);
    #1;
    if (reg_q.size() != 0) begin
      e = reg_q.pop_front();
      chk("n22_q", 32'(w22q), 32'(e.q22));
      chk("n23_q", 32'(w23q), 32'(e.q23));
      chk("cnt_n22", 32'(wc22), 32'(e.c22));
      chk("cnt_n23", 32'(wc23), 32'(e.c23));
      chk("s_n22_q", 32'(s22q), 32'(e.q22));
      chk("s_cnt_n22", 32'(sc22), 32'(e.s22));
      chk("s_cnt_n23", 32'(sc23), 32'(e.s23));
    end
    {n1, n2, n3, n6, n7} = v;
    cnt_clr = c;
    rst     = r;
    comb_q.push_back(gold(v));
    @(negedge clk);
    g = comb_q.pop_front();
    chk("n22", 32'(w22), 32'(g[1]));
    chk("n23", 32'(w23), 32'(g[0]));
    chk("s_n22", 32'(s22), 32'(g[1]));
    chk("s_n23", 32'(s23), 32'(g[0]));
    if (r) begin
      m_c22 = 0; m_c23 = 0; m_s22 = 0; m_s23 = 0;
      m_q22 = 0; m_q23 = 0;
    end else begin
      if (c) begin
        m_c22 = 0; m_c23 = 0; m_s22 = 0; m_s23 = 0;
      end else begin
        if (g[1] != m_q22) begin
          if (m_c22 != 16'hFFFF) m_c22++;
          if (m_s22 != 4'hF)     m_s22++;
        end
        if (g[0] != m_q23) begin
          if (m_c23 != 16'hFFFF) m_c23++;
          if (m_s23 != 4'hF)     m_s23++;
        end
      end
      m_q22 = g[1];
      m_q23 = g[0];
    end
    e.q22 = m_q22; e.q23 = m_q23;
    e.c22 = m_c22; e.c23 = m_c23;
    e.s22 = m_s22; e.s23 = m_s23;
    reg_q.push_back(e);
  endtask

  initial begin
    // reset
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);

    // fixed vectors with hand-derived results ({N22,N23})
    step(5'b00000, 1'b0, 1'b0); chk("v00000", 32'({w22, w23}), 32'b00);
    step(5'b11111, 1'b0, 1'b0); chk("v11111", 32'({w22, w23}), 32'b10);
    step(5'b10100, 1'b0, 1'b0); chk("v10100", 32'({w22, w23}), 32'b10);
    step(5'b01011, 1'b0, 1'b0); chk("v01011", 32'({w22, w23}), 32'b11);
    step(5'b00110, 1'b0, 1'b0); chk("v00110", 32'({w22, w23}), 32'b00);

    // toggle sequence after reset: three toggles each after the 4th edge
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b0);
    step(5'b01011, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    step(5'b01011, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    chk("seq_cnt_n22", 32'(wc22), 32'd3);
    chk("seq_cnt_n23", 32'(wc23), 32'd3);

    // all 32 vectors
    for (int i = 0; i < 32; i++) step(5'(i), 1'b0, 1'b0);

    // saturation of the 4-bit copy, then clear
    step(5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step((i % 2) ? 5'b01011 : 5'b00000, 1'b0, 1'b0);
    step(5'b01011, 1'b1, 1'b0);
    chk("sat_s_cnt_n22", 32'(sc22), 32'd15);
    chk("sat_s_cnt_n23", 32'(sc23), 32'd15);
    step(5'b01011, 1'b0, 1'b0);
    chk("clr_s_cnt_n22", 32'(sc22), 32'd0);
    chk("clr_cnt_n22", 32'(wc22), 32'd0);
    chk("clr_q_loads", 32'(w22q), 32'd1);

    // random run, then reset + clear together mid-run
    for (int i = 0; i < 12; i++) step(5'($urandom_range(0, 31)), 1'b0, 1'b0);
    step(5'b01011, 1'b1, 1'b1);
    chk("rst_comb_n22", 32'(w22), 32'd1);
    chk("rst_comb_n23", 32'(w23), 32'd1);
    step(5'b11111, 1'b0, 1'b0);
    chk("rst_q", 32'({w22q, w23q}), 32'b00);
    chk("rst_cnt", 32'({wc22, wc23}), 32'd0);
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
